alu_result_fifo: RTL and testbench

Downstream capture stage for the registered 32-bit ALU. It aligns an `issue` strobe with the ALU's one-cycle registered latency and writes each issued operation's result and flags into a small first-word-fall-through FIFO. It presents that FIFO to the consumer through a valid/pop interface and accumulates sticky status flags.

---
 rtl/alu_result_fifo.sv | 116 +++++++++++
 tb/tb_alu_result_fifo.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: capture stage behind the registered ALU.
// Delays the issue strobe by one cycle to line up with the ALU's registered
// outputs, then pushes {overflow, carryout, zero, result} into a small
// first-word-fall-through FIFO that the consumer drains with a valid/pop handshake.
// Optional feature macro: ALU_RESULT_FIFO_STICKY_EN enables sticky_flags
// accumulation. When it is undefined, sticky_flags reads 3'b000 and
// clear_sticky clears only dropped.
module alu_result_fifo #(
  parameter int NUMBITS = 32,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       issue,
  input  logic [NUMBITS-1:0]         alu_result,
  input  logic                       alu_carryout,
  input  logic                       alu_overflow,
  input  logic                       alu_zero,
  input  logic                       pop,
  input  logic                       clear_sticky,
  output logic                       out_valid,
  output logic [NUMBITS-1:0]         out_result,
  output logic [2:0]                 out_flags,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       dropped,
  output logic [2:0]                 sticky_flags
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = NUMBITS + 3;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic          issue_d;
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          eff_pop;
  logic          push_ok;
  logic          push_rej;
  logic [2:0]    in_flags;

  assign in_flags  = {alu_overflow, alu_carryout, alu_zero};
  assign out_valid = (count != '0);
  assign full      = (count == DEPTH_C);
  assign eff_pop   = pop && out_valid;
  // A full FIFO can still take a push when the head leaves on the same edge.
  assign push_ok   = issue_d && ((count < DEPTH_C) || eff_pop);
  assign push_rej  = issue_d && !push_ok;

  assign out_result = mem[rd_ptr][NUMBITS-1:0];
  assign out_flags  = mem[rd_ptr][EW-1:NUMBITS];

  // Align issue with the ALU's one-cycle registered latency.
  always_ff @(posedge clk) begin
    if (reset) issue_d <= 1'b0;
    else       issue_d <= issue;
  end

  // Storage write; cleared on reset so the head never reads X while empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[wr_ptr] <= {in_flags, alu_result};
    end
  end

  // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (eff_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy tracked explicitly: simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({push_ok, eff_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Lost-capture flag; a same-cycle rejection beats clear_sticky.
  always_ff @(posedge clk) begin
    if (reset)             dropped <= 1'b0;
    else if (push_rej)     dropped <= 1'b1;
    else if (clear_sticky) dropped <= 1'b0;
  end

`ifdef ALU_RESULT_FIFO_STICKY_EN
  // Sticky flag accumulation; an accepted push's flags survive a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_flags <= 3'b000;
    end else if (push_ok) begin
      sticky_flags <= clear_sticky ? in_flags : (sticky_flags | in_flags);
    end else if (clear_sticky) begin
      sticky_flags <= 3'b000;
    end
  end
`else
  assign sticky_flags = 3'b000;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo. The ALU itself is replaced by a register
// that loads hand-computed result/flags in the issue cycle, mimicking the
// ALU's one-cycle registered latency.
module tb_alu_result_fifo;

  localparam int NUMBITS = 32;
  localparam int DEPTH   = 4;

`ifdef ALU_RESULT_FIFO_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic               issue;
  logic [NUMBITS-1:0] alu_result;
  logic               alu_carryout;
  logic               alu_overflow;
  logic               alu_zero;
  logic               pop;
  logic               clear_sticky;
  logic               out_valid;
  logic [NUMBITS-1:0] out_result;
  logic [2:0]         out_flags;
  logic [$clog2(DEPTH):0] count;
  logic               full;
  logic               dropped;
  logic [2:0]         sticky_flags;

  // Operand-side values for the ALU stand-in: {overflow, carryout, zero}.
  logic [NUMBITS-1:0] nres;
  logic [2:0]         nflg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // ALU output register stand-in.
  always @(posedge clk) begin
    alu_result   <= nres;
    alu_overflow <= nflg[2];
    alu_carryout <= nflg[1];
    alu_zero     <= nflg[0];
  end

  alu_result_fifo #(.NUMBITS(NUMBITS), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .issue(issue),
    .alu_result(alu_result), .alu_carryout(alu_carryout),
    .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .pop(pop), .clear_sticky(clear_sticky),
    .out_valid(out_valid), .out_result(out_result), .out_flags(out_flags),
    .count(count), .full(full), .dropped(dropped), .sticky_flags(sticky_flags)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_one(input logic [NUMBITS-1:0] r, input logic [2:0] f);
    issue = 1'b1; nres = r; nflg = f;
    tick();
    issue = 1'b0; nres = '0; nflg = 3'b000;
  endtask

  task automatic pop_one();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  initial begin
    reset = 1'b1; issue = 1'b1; pop = 1'b1; clear_sticky = 1'b0;
    nres = 32'hDEAD_BEEF; nflg = 3'b111;

    // Reset held two cycles with issue and pop asserted.
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_full", 64'(full), 64'd0);
      chk("rst_dropped", 64'(dropped), 64'd0);
      chk("rst_sticky", 64'(sticky_flags), 64'd0);
      chk("rst_result", 64'(out_result), 64'd0);
    end
    reset = 1'b0; issue = 1'b0; pop = 1'b0; nres = '0; nflg = 3'b000;
    tick();
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    tick();
    chk("post_rst_count", 64'(count), 64'd0);
    chk("post_rst_result", 64'(out_result), 64'd0);

    // Pop while empty is ignored.
    pop_one();
    chk("empty_pop_count", 64'(count), 64'd0);

    // Single capture: 5 + 3 = 8, flags 000, visible two edges after issue.
    issue_one(32'd8, 3'b000);
    chk("single_valid_e1", 64'(out_valid), 64'd0);
    tick();
    chk("single_valid_e2", 64'(out_valid), 64'd1);
    chk("single_result", 64'(out_result), 64'd8);
    chk("single_flags", 64'(out_flags), 64'd0);
    chk("single_count", 64'(count), 64'd1);
    pop_one();
    chk("single_pop_count", 64'(count), 64'd0);
    chk("single_pop_valid", 64'(out_valid), 64'd0);

    // Fill and drop: results 0..4 back to back (0 + 0 sets zero flag), no pop.
    for (int i = 0; i < 5; i++) begin
      issue = 1'b1; nres = NUMBITS'(i); nflg = (i == 0) ? 3'b001 : 3'b000;
      tick();
    end
    issue = 1'b0; nres = '0; nflg = 3'b000;
    tick();
    tick();
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_dropped", 64'(dropped), 64'd1);
    chk("fill_sticky", 64'(sticky_flags), STICKY ? 64'd1 : 64'd0);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("fill_head%0d", j), 64'(out_result), 64'(j));
      chk($sformatf("fill_flags%0d", j), 64'(out_flags), (j == 0) ? 64'd1 : 64'd0);
      pop_one();
    end
    chk("fill_drain_valid", 64'(out_valid), 64'd0);
    chk("fill_drain_full", 64'(full), 64'd0);
    chk("fill_drop_stays", 64'(dropped), 64'd1);
    clear_sticky = 1'b1;
    tick();
    clear_sticky = 1'b0;
    chk("clear_dropped", 64'(dropped), 64'd0);
    chk("clear_sticky0", 64'(sticky_flags), 64'd0);

    // Full with simultaneous push and pop.
    for (int i = 0; i < 4; i++) begin
      issue = 1'b1; nres = 32'd10 + NUMBITS'(i); nflg = 3'b000;
      tick();
    end
    issue = 1'b0;
    tick();
    chk("sim_pre_count", 64'(count), 64'd4);
    issue_one(32'd14, 3'b000);
    pop_one();
    chk("sim_count", 64'(count), 64'd4);
    chk("sim_dropped", 64'(dropped), 64'd0);
    chk("sim_full", 64'(full), 64'd1);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("sim_head%0d", j), 64'(out_result), 64'd11 + 64'(j));
      pop_one();
    end
    chk("sim_empty", 64'(count), 64'd0);

    // Sticky: 7FFFFFFF + 1 overflows, flags {ovf,cy,z} = 100.
    issue_one(32'h8000_0000, 3'b100);
    tick();
    chk("stk_flags", 64'(out_flags), 64'd4);
    chk("stk_result", 64'(out_result), 64'h8000_0000);
    chk("stk_sticky", 64'(sticky_flags), STICKY ? 64'd4 : 64'd0);
    pop_one();
    clear_sticky = 1'b1;
    tick();
    clear_sticky = 1'b0;
    chk("stk_cleared", 64'(sticky_flags), 64'd0);

    // Set wins over clear: push with carry flag on the same edge as clear_sticky.
    issue_one(32'd1, 3'b010);
    clear_sticky = 1'b1;
    tick();
    clear_sticky = 1'b0;
    chk("stk_set_wins", 64'(sticky_flags), STICKY ? 64'd2 : 64'd0);
    chk("stk_set_count", 64'(count), 64'd1);
    pop_one();

    // Reset mid-operation: two stored, one capture in flight.
    issue_one(32'd21, 3'b000);
    issue_one(32'd22, 3'b000);
    tick();
    chk("mid_pre_count", 64'(count), 64'd2);
    issue_one(32'd23, 3'b000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_count", 64'(count), 64'd0);
    chk("mid_valid", 64'(out_valid), 64'd0);
    tick();
    chk("mid_no_write_count", 64'(count), 64'd0);
    chk("mid_no_write_valid", 64'(out_valid), 64'd0);
    chk("mid_result", 64'(out_result), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
